// File: rtl/lmsm_pkg.sv
// Shared types and sizing for the load/store-multiple sequencer.
package lmsm_pkg;
  localparam int LMSM_AW    = 6;
  localparam int LMSM_DW    = 16;
  localparam int LMSM_NREGS = 8;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} lmsm_state_e;
endpackage

// File: rtl/lmsm_sequencer_if.sv
// Memory and register-file side bus of the LM/SM sequencer.
interface lmsm_sequencer_if
  import lmsm_pkg::*;
#(
  parameter int AW = LMSM_AW,
  parameter int DW = LMSM_DW,
  parameter int IW = $clog2(LMSM_NREGS)
);
  logic [AW-1:0] mem_address;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_in;
  logic [DW-1:0] mem_out;
  logic [IW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic [IW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          rf_we;

  modport master (
    output mem_address, mem_read, mem_write, mem_in,
    output rf_raddr, rf_waddr, rf_wdata, rf_we,
    input  mem_out, rf_rdata
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_in,
    input  rf_raddr, rf_waddr, rf_wdata, rf_we,
    output mem_out, rf_rdata
  );
endinterface

// File: rtl/lmsm_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest 1 in vec, plus an any-bit flag.
module lmsm_prio_enc #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);
  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lmsm_sequencer.sv
// Load/store-multiple sequencer: walks a register mask lowest-first, one memory word per cycle.
// Optional macro LMSM_BASE_UPDATE_EN exposes the post-transfer base address in DONE.
module lmsm_sequencer
  import lmsm_pkg::*;
#(
  parameter int NREGS = LMSM_NREGS,
  parameter int AW    = LMSM_AW,
  parameter int DW    = LMSM_DW,
  localparam int IW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_store,
  input  logic [AW-1:0]    base_addr,
  input  logic [NREGS-1:0] reg_mask,
  output logic             busy,
  output logic             done,
  lmsm_sequencer_if.master bus,
  output logic [AW-1:0]    base_wb_addr,
  output logic             base_wb_valid
);
  lmsm_state_e      state_q, state_d;
  logic [AW-1:0]    addr_q;
  logic [NREGS-1:0] mask_q, mask_nxt;
  logic             store_q;
  logic             wb_pend_q;
  logic [IW-1:0]    wb_idx_q;
  logic [DW-1:0]    wb_data_q;

  logic [IW-1:0]    k;
  logic             any;
  logic             xfer, last;

  lmsm_prio_enc #(.N(NREGS), .IW(IW)) u_enc (
    .vec (mask_q),
    .idx (k),
    .any (any)
  );

  assign mask_nxt = mask_q & ~(NREGS'(1) << k);
  assign last     = ~|mask_nxt;
  assign xfer     = (state_q == XFER) && any;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (reg_mask == '0) ? DONE : XFER;
      XFER:    if (last)  state_d = store_q ? DONE : DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      mask_q    <= '0;
      store_q   <= 1'b0;
      wb_pend_q <= 1'b0;
      wb_idx_q  <= '0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        addr_q  <= base_addr;
        mask_q  <= reg_mask;
        store_q <= is_store;
      end
      if (xfer) begin
        mask_q <= mask_nxt;
        addr_q <= addr_q + AW'(1);
      end
      // LM read data is captured here, before the next negedge overwrites mem_out.
      wb_pend_q <= xfer && !store_q;
      if (xfer && !store_q) begin
        wb_idx_q  <= k;
        wb_data_q <= bus.mem_out;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  assign bus.mem_address = xfer ? addr_q : '0;
  assign bus.mem_read    = !(xfer && !store_q);
  assign bus.mem_write   = !(xfer && store_q);
  assign bus.rf_raddr    = (xfer && store_q) ? k : '0;
  assign bus.mem_in      = (xfer && store_q) ? bus.rf_rdata : '0;
  assign bus.rf_we       = wb_pend_q;
  assign bus.rf_waddr    = wb_idx_q;
  assign bus.rf_wdata    = wb_data_q;

`ifdef LMSM_BASE_UPDATE_EN
  // addr_q has advanced once per selected register, so in DONE it equals base + popcount(mask).
  assign base_wb_valid = done;
  assign base_wb_addr  = done ? addr_q : '0;
`else
  assign base_wb_valid = 1'b0;
  assign base_wb_addr  = '0;
`endif
endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer with behavioural memory/register file and an access scoreboard.
module tb_lmsm_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [5:0]  base_addr;
  logic [7:0]  reg_mask;
  logic        busy, done;
  logic [5:0]  base_wb_addr;
  logic        base_wb_valid;

  int checks = 0;
  int errors = 0;

  lmsm_sequencer_if bus ();

  lmsm_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .is_store      (is_store),
    .base_addr     (base_addr),
    .reg_mask      (reg_mask),
    .busy          (busy),
    .done          (done),
    .bus           (bus),
    .base_wb_addr  (base_wb_addr),
    .base_wb_valid (base_wb_valid)
  );

  always #5 clk = ~clk;

  // Environment: 64x16 memory acting on negedge, register file with combinational read.
  logic [15:0] mem [64];
  logic [15:0] rf  [8];
  logic        pl_mem_we = 1'b0, pl_rf_we = 1'b0;
  logic [5:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(negedge clk) begin
    if (pl_mem_we) mem[pl_addr] <= pl_data;
    else begin
      if (!bus.mem_write) mem[bus.mem_address] <= bus.mem_in;
      if (!bus.mem_read)  bus.mem_out <= mem[bus.mem_address];
    end
  end

  always @(posedge clk) begin
    if (pl_rf_we)        rf[pl_addr[2:0]] <= pl_data;
    else if (bus.rf_we)  rf[bus.rf_waddr] <= bus.rf_wdata;
  end

  assign bus.rf_rdata = rf[bus.rf_raddr];

  // Bench model and scoreboard
  logic [15:0] exp_mem [64];
  logic [15:0] exp_rf  [8];

  typedef struct { int cyc; logic wr; logic [5:0] addr; logic [15:0] data; } acc_t;
  typedef struct { int cyc; logic [2:0] idx; logic [15:0] data; } wb_t;
  acc_t acc_q[$];
  wb_t  wb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic preload_mem(input logic [5:0] a, input logic [15:0] d);
    pl_mem_we = 1'b1; pl_addr = a; pl_data = d; exp_mem[a] = d;
    @(posedge clk); #1;
    pl_mem_we = 1'b0;
  endtask

  task automatic preload_rf(input logic [2:0] r, input logic [15:0] d);
    pl_rf_we = 1'b1; pl_addr = {3'b0, r}; pl_data = d; exp_rf[r] = d;
    @(posedge clk); #1;
    pl_rf_we = 1'b0;
  endtask

  task automatic verify_state(input string tag);
    for (int i = 0; i < 64; i++) chk({tag, "_mem"}, mem[i], exp_mem[i]);
    for (int i = 0; i < 8; i++)  chk({tag, "_rf"}, rf[i], exp_rf[i]);
  endtask

  // Entered and left at posedge+1 in an IDLE cycle.
  task automatic run(input logic st, input logic [5:0] base, input logic [7:0] mask, input logic poke);
    int          n = 0;
    int          dexp;
    logic        got = 1'b0;
    logic [5:0]  a = base;
    acc_t        e;
    wb_t         w;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        acc_q.push_back('{n + 1, st, a, st ? exp_rf[i] : 16'h0});
        if (st) exp_mem[a] = exp_rf[i];
        else begin
          wb_q.push_back('{n + 2, 3'(i), exp_mem[a]});
          exp_rf[i] = exp_mem[a];
        end
        a = a + 6'd1;
        n++;
      end
    end
    dexp = (n == 0) ? 1 : (st ? n + 1 : n + 2);

    start = 1'b1; is_store = st; base_addr = base; reg_mask = mask;
    @(posedge clk); #1;
    start = 1'b0; is_store = ~st; base_addr = ~base; reg_mask = ~mask;

    for (int c = 1; c <= 30 && !got; c++) begin
      chk("busy", busy, 1);
      chk("strobe_excl", (!bus.mem_read && !bus.mem_write), 0);
      if (!bus.mem_read || !bus.mem_write) begin
        if (acc_q.size() == 0) chk("acc_extra", c, 0);
        else begin
          e = acc_q.pop_front();
          chk("acc_cyc", c, e.cyc);
          chk("acc_wr", !bus.mem_write, e.wr);
          chk("acc_addr", bus.mem_address, e.addr);
          if (e.wr) chk("acc_data", bus.mem_in, e.data);
        end
      end
      if (bus.rf_we) begin
        if (wb_q.size() == 0) chk("wb_extra", c, 0);
        else begin
          w = wb_q.pop_front();
          chk("wb_cyc", c, w.cyc);
          chk("wb_idx", bus.rf_waddr, w.idx);
          chk("wb_data", bus.rf_wdata, w.data);
        end
      end
      if (done) begin
        got = 1'b1;
        chk("done_cyc", c, dexp);
`ifdef LMSM_BASE_UPDATE_EN
        chk("wb_valid", base_wb_valid, 1);
        chk("wb_addr", base_wb_addr, 32'((base + 6'(n)) & 6'h3f));
`else
        chk("wb_valid", base_wb_valid, 0);
        chk("wb_addr", base_wb_addr, 0);
`endif
      end else begin
        start = poke && (c == 1);
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
    chk("acc_left", acc_q.size(), 0);
    chk("wb_left", wb_q.size(), 0);
    acc_q.delete();
    wb_q.delete();
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; base_addr = '0; reg_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", bus.mem_read, 1);
    chk("rst_wr", bus.mem_write, 1);
    chk("rst_we", bus.rf_we, 0);
    chk("rst_addr", bus.mem_address, 0);
    chk("rst_min", bus.mem_in, 0);
    chk("rst_ridx", bus.rf_raddr, 0);
    chk("rst_widx", bus.rf_waddr, 0);
    chk("rst_wdat", bus.rf_wdata, 0);
    chk("rst_bwv", base_wb_valid, 0);
    chk("rst_bwa", base_wb_addr, 0);
    reset = 1'b0;

    for (int i = 0; i < 64; i++) preload_mem(6'(i), 16'h1000 + 16'(i * 37));
    for (int i = 0; i < 8; i++)  preload_rf(3'(i), 16'h0F00 + 16'(i));
    preload_mem(6'd10, 16'hAAAA);
    preload_mem(6'd11, 16'h5555);
    preload_rf(3'd0, 16'h1234);
    preload_rf(3'd7, 16'hBEEF);

    run(1'b0, 6'd10, 8'h05, 1'b0);
    verify_state("lm05");
    run(1'b1, 6'd20, 8'h81, 1'b0);
    verify_state("sm81");
    run(1'b0, 6'd62, 8'hFF, 1'b0);
    verify_state("lmff");
    run(1'b0, 6'd5, 8'h00, 1'b0);
    run(1'b1, 6'd7, 8'h00, 1'b0);

    // Abort an LM in its second cycle; the R4 write-back in T2 still lands.
    start = 1'b1; is_store = 1'b0; base_addr = 6'd30; reg_mask = 8'hF0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_rd", bus.mem_read, 1);
    chk("abort_wr", bus.mem_write, 1);
    chk("abort_we", bus.rf_we, 0);
    chk("abort_done", done, 0);
    reset = 1'b0;
    exp_rf[4] = exp_mem[30];
    @(posedge clk); #1;
    verify_state("abort");

    run(1'b0, 6'd33, 8'h0C, 1'b0);
    run(1'b1, 6'd40, 8'h0E, 1'b1);
    run(1'b1, 6'd63, 8'h42, 1'b0);
    verify_state("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Load-multiple/store-multiple sequencer sitting directly upstream of the 64×16 data memory in the multicycle processor. Given a base address and an 8-bit register mask, it walks the set bits lowest-first and issues one memory word access per selected register on consecutive addresses. It drives the memory's active-low read/write strobes and address, and the register file's read/write ports, then pulses `done` back to the control FSM.

## Interface
- `NREGS`, 8: register count and mask width.
- `AW`, 6: memory address width (64 words).
- `DW`, 16: data word width.

Ports:
- `clk`  in  1  single system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a transfer; sampled only when `busy`=0.
- `is_store`  in  1  1 = SM (register→memory), 0 = LM (memory→register).
- `base_addr`  in  AW  first memory address.
- `reg_mask`  in  NREGS  bit i selects register Ri.
- `busy`  out  1  transfer in progress, including the done cycle.
- `done`  out  1  one-cycle completion pulse.
- `mem_address`  out  AW  memory address.
- `mem_read`  out  1  active-low read strobe.
- `mem_write`  out  1  active-low write strobe.
- `mem_in`  out  DW  store data to memory.
- `mem_out`  in  DW  memory read data (memory updates it on negedge).
- `rf_raddr`  out  3  register-file read index (SM).
- `rf_rdata`  in  DW  combinational register-file read data.
- `rf_waddr`  out  3  register-file write index (LM).
- `rf_wdata`  out  DW  register-file write data.
- `rf_we`  out  1  active-high register-file write enable.
- `base_wb_addr`  out  AW  final address (see Configuration).
- `base_wb_valid`  out  1  final address valid (see Configuration).

## Operation
- States: IDLE, XFER, DRAIN, DONE.
- IDLE: when `start`=1, latch `base_addr`, `reg_mask` and `is_store`.
  - Non-zero mask: go to XFER.
  - Zero mask: go to DONE with no memory access.
- XFER, one cycle per selected register:
  - Index k is the lowest set bit of the remaining mask.
  - `mem_address` = current address.
  - LM: `mem_read`=0. SM: `mem_write`=0, `rf_raddr`=k, `mem_in`=`rf_rdata`.
  - At the posedge: clear bit k and increment the address modulo 2^AW (63 wraps to 0).
  - Last bit cleared: LM goes to DRAIN, SM goes to DONE.
- LM write-back:
  - At the posedge ending each read cycle, capture `mem_out` into a data register and k into a write-index register.
  - In the following cycle: `rf_we`=1, `rf_waddr`/`rf_wdata` come from those registers.
  - Write-back overlaps the next XFER cycle.
  - DRAIN performs the final write-back only, with no memory access.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` while `busy`=1 is ignored. Latched inputs do not change mid-transfer.
- Outside access cycles `mem_read`=`mem_write`=1. `mem_read` and `mem_write` are never both 0.
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `rf_we`=0, `base_wb_valid`=0.
  - `mem_read`=1, `mem_write`=1.
  - Address, data and index outputs 0.
- Reset mid-transfer aborts at once. A write already captured by memory is not undone.

## Timing
- `start` is sampled at posedge T0. The first access is in cycle T1, and `busy` is high from T1 through the DONE cycle.
- N selected registers:
  - SM: accesses T1..TN, `done` at TN+1.
  - LM: accesses T1..TN, `rf_we` T2..TN+1, `done` at TN+2.
  - Empty mask: `done` at T1.
- The memory acts on the negedge inside each access cycle. LM data is captured at the posedge that ends that cycle, before the next negedge overwrites `mem_out`.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after DONE.

## Configuration
- `LMSM_BASE_UPDATE_EN` defined:
  - In DONE, `base_wb_valid`=1 and `base_wb_addr` = base + popcount(mask), modulo 2^AW.
  - The control FSM uses this for base-register auto-increment.
- Not defined: both outputs are tied to 0 and the adder logic is omitted.

## Structure
- Shared package `lmsm_pkg` holds:
  - the state enum (IDLE, XFER, DRAIN, DONE);
  - the constants `LMSM_AW`=6, `LMSM_DW`=16, `LMSM_NREGS`=8.
- Sub-module `lmsm_prio_enc`: combinational lowest-set-bit encoder, 8→3 index plus `any` flag, shared by next-index and last-bit detection.

## Test plan
- LM, mask 0x05, base 10, mem[10]=0xAAAA, mem[11]=0x5555 → reads at 10 and 11 in T1–T2; R0←0xAAAA at T2, R2←0x5555 at T3; `done` at T4.
- SM, mask 0x81, base 20, R0=0x1234, R7=0xBEEF → `mem_write` low T1–T2, mem[20]=0x1234, mem[21]=0xBEEF, `done` at T3, `rf_we` never asserted.
- LM, mask 0xFF, base 62 → addresses 62, 63, 0, 1…5 in order; R0..R7 loaded; `done` at T10; with `LMSM_BASE_UPDATE_EN`, `base_wb_addr`=6.
- Mask 0x00 → `done` at T1, strobes stay 1, `rf_we` stays 0.
- `reset` asserted in T2 of an LM with mask 0xF0 → at T3 `busy`=0, strobes 1, `rf_we`=0; a new `start` works normally.
- `start` pulsed during a busy SM with a different mask and base → ignored; original transfer completes unchanged.
